// File: rtl/key_event_pkg.sv
// Shared types for the keycode event queue: event record and FSM state encoding.
// Purely declarative; no timing or flow-control behaviour lives here.
package key_event_pkg;

  localparam int KEY_WIDTH = 8;
  localparam logic [KEY_WIDTH-1:0] KEY_NONE = 8'h00;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic                 pressed;
  } key_event_t;

  typedef enum logic {
    IDLE,
    PUSH_PRESS
  } kq_state_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO of key events; head visible combinationally, 0 cycles read latency.
// Writes while full are refused unless a pop happens on the same edge; reads while empty are ignored.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       wr_en,
  input  key_event_t                 wr_data,
  input  logic                       rd_en,
  output key_event_t                 rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  key_event_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_pop;
  logic              do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = wr_en && (!full || do_pop);

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns keycode level changes into press/release events in a FWFT queue; first event 2 edges after a change.
// Consumer pops via rd_en; events arriving while full are dropped and flagged in sticky overflow.
module keycode_event_queue
  import key_event_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KEY_W = KEY_WIDTH
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [KEY_W-1:0]           keycode,
  input  logic                       rd_en,
  output logic                       ev_valid,
  output logic [KEY_W-1:0]           ev_key,
  output logic                       ev_pressed,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  kq_state_t         state;
  kq_state_t         state_d;
  logic [KEY_W-1:0]  kc_q;
  logic [KEY_W-1:0]  cur_key;
  logic [KEY_W-1:0]  cur_key_d;
  logic [KEY_W-1:0]  pend_key;
  logic [KEY_W-1:0]  pend_key_d;

  logic              push;
  key_event_t        push_ev;
  key_event_t        head_ev;
  logic              fifo_empty;
  logic              fifo_full;
  logic              drop;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q     <= '0;
      cur_key  <= '0;
      pend_key <= '0;
      state    <= IDLE;
    end else begin
      kc_q     <= keycode;
      cur_key  <= cur_key_d;
      pend_key <= pend_key_d;
      state    <= state_d;
    end
  end

  // A key-to-key change is split into release(old) now and press(new) next cycle,
  // keeping to one push per edge.
  always_comb begin
    state_d    = state;
    cur_key_d  = cur_key;
    pend_key_d = pend_key;
    push       = 1'b0;
    push_ev    = '0;
    case (state)
      IDLE: begin
        if (kc_q != cur_key) begin
          cur_key_d = kc_q;
          push      = 1'b1;
          if (cur_key != KEY_NONE) begin
            push_ev.key     = cur_key;
            push_ev.pressed = 1'b0;
            if (kc_q != KEY_NONE) begin
              pend_key_d = kc_q;
              state_d    = PUSH_PRESS;
            end
          end else begin
            push_ev.key     = kc_q;
            push_ev.pressed = 1'b1;
          end
        end
      end
      PUSH_PRESS: begin
        push            = 1'b1;
        push_ev.key     = pend_key;
        push_ev.pressed = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  key_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (push),
    .wr_data (push_ev),
    .rd_en   (rd_en),
    .rd_data (head_ev),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

  // Full FIFO is never empty, so a pop request here is always honoured.
  assign drop = push && fifo_full && !rd_en;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign ev_valid   = !fifo_empty;
  assign ev_key     = fifo_empty ? '0 : head_ev.key;
  assign ev_pressed = fifo_empty ? 1'b0 : head_ev.pressed;

endmodule
